// File: rtl/mp_rcv_det_lane_arb.sv
`default_nettype none
// ============================================================================
//  Module   : mp_rcv_det_lane_arb
//  Purpose  : Round-robin arbiter sharing one PMA receiver-detect engine
//             across NUM_LANES PIPE lanes, with req/done handshake and timeout.
//  Revision : 1.0  initial release
// ============================================================================
module mp_rcv_det_lane_arb #(
  parameter int NUM_LANES = 4,
  parameter int TMO_W     = 16
) (
  input  logic                         pipe_clk,
  input  logic                         pipe_rst_n,
  input  logic                         cfg_en,
  input  logic [TMO_W-1:0]             cfg_tmo_cnt,
  input  logic [NUM_LANES-1:0]         lane_req,
  output logic [NUM_LANES-1:0]         lane_ack,
  output logic [NUM_LANES-1:0]         lane_det,
  output logic                         det_req,
  output logic [$clog2(NUM_LANES)-1:0] det_lane_sel,
  input  logic                         det_done,
  input  logic                         det_result,
  output logic                         det_tmo_err,
  output logic                         busy
);

  localparam int SEL_W = $clog2(NUM_LANES);
  localparam logic [SEL_W:0] NL = NUM_LANES[SEL_W:0];

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_REL  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [SEL_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [SEL_W-1:0]       sel_q, sel_d;
  logic                   det_req_q, det_req_d;
  logic [TMO_W-1:0]       tmo_cnt_q, tmo_cnt_d;
  logic                   tmo_en_q, tmo_en_d;
  logic [NUM_LANES-1:0]   lane_ack_q, lane_ack_d;
  logic [NUM_LANES-1:0]   lane_det_q, lane_det_d;
  logic                   tmo_err_q, tmo_err_d;

  logic                   gnt_vld;
  logic [SEL_W-1:0]       gnt_idx;
  logic [SEL_W:0]         idx_sum;
  logic [SEL_W:0]         nxt_ptr;

  // First requesting lane at or after rr_ptr, wrapping past the top lane.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx_sum = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      idx_sum = {1'b0, rr_ptr_q} + (SEL_W+1)'(i);
      if (idx_sum >= NL) idx_sum = idx_sum - NL;
      if (!gnt_vld && lane_req[idx_sum[SEL_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx_sum[SEL_W-1:0];
      end
    end
  end

  always_comb begin
    nxt_ptr = {1'b0, sel_q} + 1'b1;
    if (nxt_ptr >= NL) nxt_ptr = '0;
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    sel_d      = sel_q;
    det_req_d  = det_req_q;
    tmo_cnt_d  = tmo_cnt_q;
    tmo_en_d   = tmo_en_q;
    lane_ack_d = '0;
    lane_det_d = '0;
    tmo_err_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A done still high from the previous op must clear before a new grant.
        if (cfg_en && gnt_vld && !det_done) begin
          sel_d     = gnt_idx;
          det_req_d = 1'b1;
          tmo_cnt_d = cfg_tmo_cnt;
          tmo_en_d  = |cfg_tmo_cnt;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        if (det_done) begin
          det_req_d         = 1'b0;
          lane_ack_d[sel_q] = lane_req[sel_q];
          lane_det_d[sel_q] = lane_req[sel_q] & det_result;
          state_d           = ST_REL;
        end else if (tmo_en_q && (tmo_cnt_q == '0)) begin
          det_req_d         = 1'b0;
          lane_ack_d[sel_q] = lane_req[sel_q];
          tmo_err_d         = 1'b1;
          state_d           = ST_REL;
        end else if (tmo_en_q) begin
          tmo_cnt_d = tmo_cnt_q - 1'b1;
        end
      end
      ST_REL: begin
        if (!det_done) begin
          rr_ptr_d = nxt_ptr[SEL_W-1:0];
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pipe_clk or negedge pipe_rst_n) begin
    if (!pipe_rst_n) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      sel_q      <= '0;
      det_req_q  <= 1'b0;
      tmo_cnt_q  <= '0;
      tmo_en_q   <= 1'b0;
      lane_ack_q <= '0;
      lane_det_q <= '0;
      tmo_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      sel_q      <= sel_d;
      det_req_q  <= det_req_d;
      tmo_cnt_q  <= tmo_cnt_d;
      tmo_en_q   <= tmo_en_d;
      lane_ack_q <= lane_ack_d;
      lane_det_q <= lane_det_d;
      tmo_err_q  <= tmo_err_d;
    end
  end

  assign lane_ack     = lane_ack_q;
  assign lane_det     = lane_det_q;
  assign det_req      = det_req_q;
  assign det_lane_sel = sel_q;
  assign det_tmo_err  = tmo_err_q;
  assign busy         = (state_q != ST_IDLE);

endmodule
`default_nettype wire
